// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: tap constants, step function and lock-up state.
package lfsr_pkg;

  localparam int unsigned   MaxWidth  = 64;
  localparam logic [31:0]   PeriodMax = 32'hFFFF_FFFF;

  localparam logic [15:0]   TAPS16 = 16'hD008;
  localparam logic [63:0]   TAPS64 = 64'hD800_0000_0000_0000;
  localparam logic [3:0]    TAPS4  = 4'hC;

  // Mask covering the low 'width' bits of a MaxWidth vector.
  function automatic logic [MaxWidth-1:0] lfsr_mask(input int unsigned width);
    if (width >= MaxWidth) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [MaxWidth-1:0] lfsr_step(input logic [MaxWidth-1:0] state,
                                                    input logic [MaxWidth-1:0] taps,
                                                    input int unsigned         width,
                                                    input logic                xnor_fb);
    logic fb;
    fb = (^(state & taps)) ^ xnor_fb;
    return ((state << 1) | {{(MaxWidth-1){1'b0}}, fb}) & lfsr_mask(width);
  endfunction

  // The one state the feedback can never leave: all ones for XNOR, all zeros for XOR.
  function automatic logic [MaxWidth-1:0] lfsr_lockup(input int unsigned width,
                                                      input logic        xnor_fb);
    return xnor_fb ? lfsr_mask(width) : '0;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Combinational STEPS-deep unrolled LFSR stepper.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS16),
  parameter bit               XNOR  = 1'b1,
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [MaxWidth-1:0] chain [STEPS+1];

  assign chain[0] = MaxWidth'(state_i);

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign chain[k+1] = lfsr_step(chain[k], MaxWidth'(TAPS), WIDTH, XNOR);
  end

  assign state_o = chain[STEPS][WIDTH-1:0];

  // Upper bits are always masked to zero by the step function.
  if (WIDTH < MaxWidth) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^chain[STEPS][MaxWidth-1:WIDTH];
  end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR pseudo-random source with seed load, lock-up recovery and period reporting.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter bit               XNOR  = 1'b1,
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] state_o,
  output logic [STEPS-1:0] out_bits_o,
  output logic             valid_o,
  output logic             lockup_o,
  output logic             wrap_o,
  output logic [31:0]      period_o
);

  localparam logic [MaxWidth-1:0] LockWide  = lfsr_lockup(WIDTH, XNOR);
  localparam logic [WIDTH-1:0]    LockState = LockWide[WIDTH-1:0];
  localparam logic [32:0]         StepInc   = 33'(STEPS);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] stepped;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      cnt_inc;
  logic [32:0]      cnt_sum;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .XNOR  (XNOR),
    .STEPS (STEPS)
  ) u_core (
    .state_i (state_q),
    .state_o (stepped)
  );

  // Saturating step count including the steps taken this cycle.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + StepInc;
    cnt_inc = cnt_sum[32] ? PeriodMax : cnt_sum[31:0];
  end

  // Next state: load beats lock-up recovery, which beats an enabled step.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    if (load_i) begin
      if (load_value_i == LockState) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = load_value_i;
      end
      ref_d = state_d;
      cnt_d = '0;
    end else if (state_q == LockState) begin
      state_d  = SEED;
      lockup_d = 1'b1;
    end else if (enable_i) begin
      state_d = stepped;
      valid_d = 1'b1;
      // Only the post-cycle state is compared; intermediate matches are ignored.
      if (stepped == ref_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign state_o    = state_q;
  assign out_bits_o = state_q[STEPS-1:0];
  assign valid_o    = valid_q;
  assign lockup_o   = lockup_q;
  assign wrap_o     = wrap_q;
  assign period_o   = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: four configurations share stimulus and are checked against
// a behavioural model every cycle, plus literal expectations from hand calculation.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ld;
  logic [63:0] lv;

  always #5 clk = ~clk;

  // Instance 0: defaults (16b, XNOR, 1 step).
  logic [15:0] st0;
  logic [0:0]  ob0;
  logic        v0, lk0, w0;
  logic [31:0] p0;
  // Instance 1: XOR feedback.
  logic [15:0] st1;
  logic [0:0]  ob1;
  logic        v1, lk1, w1;
  logic [31:0] p1;
  // Instance 2: 4 steps per cycle.
  logic [15:0] st2;
  logic [3:0]  ob2;
  logic        v2, lk2, w2;
  logic [31:0] p2;
  // Instance 3: 4-bit XOR, period 15.
  logic [3:0]  st3;
  logic [0:0]  ob3;
  logic        v3, lk3, w3;
  logic [31:0] p3;

  lfsr_gen u_dut0 (
    .clk_i(clk), .reset_ni(rst_n), .enable_i(en), .load_i(ld), .load_value_i(lv[15:0]),
    .state_o(st0), .out_bits_o(ob0), .valid_o(v0), .lockup_o(lk0), .wrap_o(w0), .period_o(p0)
  );

  lfsr_gen #(.XNOR(1'b0)) u_dut1 (
    .clk_i(clk), .reset_ni(rst_n), .enable_i(en), .load_i(ld), .load_value_i(lv[15:0]),
    .state_o(st1), .out_bits_o(ob1), .valid_o(v1), .lockup_o(lk1), .wrap_o(w1), .period_o(p1)
  );

  lfsr_gen #(.STEPS(4)) u_dut2 (
    .clk_i(clk), .reset_ni(rst_n), .enable_i(en), .load_i(ld), .load_value_i(lv[15:0]),
    .state_o(st2), .out_bits_o(ob2), .valid_o(v2), .lockup_o(lk2), .wrap_o(w2), .period_o(p2)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .XNOR(1'b0)) u_dut3 (
    .clk_i(clk), .reset_ni(rst_n), .enable_i(en), .load_i(ld), .load_value_i(lv[3:0]),
    .state_o(st3), .out_bits_o(ob3), .valid_o(v3), .lockup_o(lk3), .wrap_o(w3), .period_o(p3)
  );

  logic [63:0] d_state [4];
  logic [63:0] d_ob    [4];
  logic [63:0] d_valid [4];
  logic [63:0] d_lock  [4];
  logic [63:0] d_wrap  [4];
  logic [63:0] d_per   [4];

  assign d_state[0] = 64'(st0);
  assign d_state[1] = 64'(st1);
  assign d_state[2] = 64'(st2);
  assign d_state[3] = 64'(st3);
  assign d_ob[0]    = 64'(ob0);
  assign d_ob[1]    = 64'(ob1);
  assign d_ob[2]    = 64'(ob2);
  assign d_ob[3]    = 64'(ob3);
  assign d_valid[0] = 64'(v0);
  assign d_valid[1] = 64'(v1);
  assign d_valid[2] = 64'(v2);
  assign d_valid[3] = 64'(v3);
  assign d_lock[0]  = 64'(lk0);
  assign d_lock[1]  = 64'(lk1);
  assign d_lock[2]  = 64'(lk2);
  assign d_lock[3]  = 64'(lk3);
  assign d_wrap[0]  = 64'(w0);
  assign d_wrap[1]  = 64'(w1);
  assign d_wrap[2]  = 64'(w2);
  assign d_wrap[3]  = 64'(w3);
  assign d_per[0]   = 64'(p0);
  assign d_per[1]   = 64'(p1);
  assign d_per[2]   = 64'(p2);
  assign d_per[3]   = 64'(p3);

  // Per-instance configuration.
  function automatic int unsigned c_width(input int i);
    return (i == 3) ? 4 : 16;
  endfunction
  function automatic logic [63:0] c_taps(input int i);
    return (i == 3) ? 64'hC : 64'hD008;
  endfunction
  function automatic logic c_xnor(input int i);
    return (i == 0 || i == 2);
  endfunction
  function automatic int unsigned c_steps(input int i);
    return (i == 2) ? 4 : 1;
  endfunction
  function automatic logic [63:0] c_mask(input int i);
    return (64'd1 << c_width(i)) - 64'd1;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) begin
        $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
      end
    end
  endtask

  // Behavioural model: state as a number, feedback as tap-count parity.
  logic [63:0] m_state [4];
  logic [63:0] m_ref   [4];
  logic [63:0] m_cnt   [4];
  logic [63:0] m_per   [4];
  logic [63:0] m_valid [4];
  logic [63:0] m_lock  [4];
  logic [63:0] m_wrap  [4];

  function automatic logic [63:0] model_step(input int i, input logic [63:0] s);
    logic fb;
    fb = logic'($countones(s & c_taps(i)) % 2) ^ c_xnor(i);
    return ((s << 1) | 64'(fb)) & c_mask(i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      logic [63:0] lock_val;
      logic [63:0] s;
      logic [63:0] sum;
      lock_val = c_xnor(i) ? c_mask(i) : 64'd0;
      if (!rst_n) begin
        m_state[i] = 64'd1;
        m_ref[i]   = 64'd1;
        m_cnt[i]   = 0;
        m_per[i]   = 0;
        m_valid[i] = 0;
        m_lock[i]  = 0;
        m_wrap[i]  = 0;
      end else begin
        m_valid[i] = 0;
        m_lock[i]  = 0;
        m_wrap[i]  = 0;
        if (ld) begin
          s = lv & c_mask(i);
          if (s == lock_val) begin
            s = 64'd1;
            m_lock[i] = 1;
          end
          m_state[i] = s;
          m_ref[i]   = s;
          m_cnt[i]   = 0;
        end else if (m_state[i] == lock_val) begin
          m_state[i] = 64'd1;
          m_lock[i]  = 1;
        end else if (en) begin
          s = m_state[i];
          for (int k = 0; k < int'(c_steps(i)); k++) s = model_step(i, s);
          m_state[i] = s;
          m_valid[i] = 1;
          sum = m_cnt[i] + 64'(c_steps(i));
          if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
          if (s == m_ref[i]) begin
            m_wrap[i] = 1;
            m_per[i]  = sum;
            m_cnt[i]  = 0;
          end else begin
            m_cnt[i] = sum;
          end
        end
      end
    end
  end

  // Compare every output of every instance against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk("state", i, d_state[i], m_state[i]);
      chk("out_bits", i, d_ob[i], m_state[i] & ((64'd1 << c_steps(i)) - 64'd1));
      chk("valid", i, d_valid[i], m_valid[i]);
      chk("lockup", i, d_lock[i], m_lock[i]);
      chk("wrap", i, d_wrap[i], m_wrap[i]);
      chk("period", i, d_per[i], m_per[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int  wrap0_cycle;
  int  wrap3_seen;
  int  r;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    ld    = 1'b0;
    lv    = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset values.
    chk("rst_state", 0, d_state[0], 64'h0001);
    chk("rst_state", 3, d_state[3], 64'h1);
    chk("rst_period", 0, d_per[0], 64'd0);
    chk("rst_valid", 0, d_valid[0], 64'd0);

    // Four enabled cycles from SEED.
    en = 1'b1;
    tick();
    chk("seq0_1", 0, d_state[0], 64'h0003);
    chk("seq1_1", 1, d_state[1], 64'h0002);
    chk("st4_state", 2, d_state[2], 64'h001E);
    chk("st4_bits", 2, d_ob[2], 64'hE);
    chk("st4_valid", 2, d_valid[2], 64'd1);
    tick();
    chk("seq0_2", 0, d_state[0], 64'h0007);
    chk("seq1_2", 1, d_state[1], 64'h0004);
    chk("seq_valid", 0, d_valid[0], 64'd1);
    tick();
    chk("seq0_3", 0, d_state[0], 64'h000F);
    chk("seq1_3", 1, d_state[1], 64'h0008);
    tick();
    chk("seq0_4", 0, d_state[0], 64'h001E);
    chk("seq1_4", 1, d_state[1], 64'h0011);
    chk("seq_valid", 0, d_valid[0], 64'd1);
    en = 1'b0;
    tick();
    chk("hold_state", 0, d_state[0], 64'h001E);
    chk("hold_valid", 0, d_valid[0], 64'd0);

    // Lock-up loads.
    ld = 1'b1;
    lv = 64'hFFFF;
    tick();
    ld = 1'b0;
    chk("lk_xnor_state", 0, d_state[0], 64'h0001);
    chk("lk_xnor_pulse", 0, d_lock[0], 64'd1);
    chk("ld_xor_state", 1, d_state[1], 64'hFFFF);
    tick();
    chk("lk_xnor_once", 0, d_lock[0], 64'd0);
    ld = 1'b1;
    lv = 64'h0;
    tick();
    ld = 1'b0;
    chk("lk_xor_state", 1, d_state[1], 64'h0001);
    chk("lk_xor_pulse", 1, d_lock[1], 64'd1);
    chk("lk_xor_state", 3, d_state[3], 64'h1);
    tick();
    chk("lk_xor_once", 1, d_lock[1], 64'd0);

    // Randomised enable/load traffic.
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(3) != 0);
      ld = ($urandom_range(31) == 0);
      r  = int'($urandom_range(3));
      lv = {$urandom(), $urandom()};
      if (r == 0) lv = '0;
      if (r == 1) lv = '1;
      tick();
    end

    // Load and enable together: no step taken.
    ld = 1'b1;
    en = 1'b1;
    lv = 64'h1234;
    tick();
    ld = 1'b0;
    chk("ld_en_state", 0, d_state[0], 64'h1234);
    chk("ld_en_valid", 0, d_valid[0], 64'd0);
    tick();
    tick();

    // Asynchronous reset between edges.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 0, d_state[0], 64'h0001);
    chk("arst_state", 2, d_state[2], 64'h0001);
    chk("arst_state", 3, d_state[3], 64'h1);
    chk("arst_period", 0, d_per[0], 64'd0);
    tick();
    rst_n = 1'b1;

    // Continuous enable: full periods.
    en = 1'b1;
    wrap0_cycle = 0;
    wrap3_seen  = 0;
    tick();
    chk("post_rst_step", 0, d_state[0], 64'h0003);
    for (int c = 2; c <= 65540; c++) begin
      tick();
      if (d_wrap[3] == 64'd1 && wrap3_seen == 0) begin
        wrap3_seen = c;
        chk("w4_period", 3, d_per[3], 64'd15);
      end
      if (d_wrap[0] == 64'd1 && wrap0_cycle == 0) wrap0_cycle = c;
    end
    chk("w4_first_wrap", 3, 64'(wrap3_seen), 64'd15);
    chk("w16_wrap_cycle", 0, 64'(wrap0_cycle), 64'd65535);
    chk("w16_period", 0, d_per[0], 64'd65535);
    en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
